crc_lut_gen: RTL and testbench

- Parametrised successor to the fixed CRC lookup-table ROMs used by the pipelined LUT CRC datapath.
- Instead of a hard-coded 256x32 table, it computes its table contents in hardware for a programmable reflected polynomial and zero-byte advance distance K.
- Entry i holds the CRC state after byte i is followed by K zero bytes. K=0 gives the plain byte table; K=n gives the slice-n table.
- It serves single-cycle registered lookups to one pipeline stage and can be refilled at runtime without resynthesis.

---
 rtl/crc_lut_pkg.sv | 27 ++
 rtl/crc_lut_stepper.sv | 24 ++
 rtl/crc_lut_gen.sv | 146 ++++++++++++++
 tb/tb_crc_lut_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_lut_pkg.sv
// Shared definitions for the CRC lookup-table generator: well-known reflected
// polynomials, the fill FSM state encoding and a single reflected CRC step.
package crc_lut_pkg;

    // Reflected (LSB-first) polynomials in common use.
    localparam logic [31:0] CRC32_POLY  = 32'hEDB88320;
    localparam logic [31:0] CRC32C_POLY = 32'h82F63B78;
    localparam logic [15:0] CRC16_POLY  = 16'hA001;

    // Widest CRC the step helper supports; narrower values ride zero-extended.
    localparam int CRC_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } crc_state_e;

    // One reflected CRC bit step. Zero-extended operands keep the upper bits at
    // zero, so callers truncate the result back to their own width.
    function automatic logic [CRC_MAX_W-1:0] crc_step(input logic [CRC_MAX_W-1:0] r,
                                                      input logic [CRC_MAX_W-1:0] poly);
        return (r >> 1) ^ (r[0] ? poly : '0);
    endfunction

endpackage

// File: rtl/crc_lut_stepper.sv
// Combinational UNROLL-bit reflected CRC advance used by the fill datapath.
module crc_lut_stepper
    import crc_lut_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] poly,
    output logic [WIDTH-1:0] r_out
);

    logic [WIDTH-1:0] acc;

    // Chain UNROLL single-bit steps in one cycle.
    always_comb begin
        acc = r_in;
        for (int i = 0; i < int'(UNROLL); i++) begin
            acc = WIDTH'(crc_step(CRC_MAX_W'(acc), CRC_MAX_W'(poly)));
        end
        r_out = acc;
    end

endmodule

// File: rtl/crc_lut_gen.sv
// Runtime-fillable CRC lookup table. Entry i holds the CRC state after byte i
// followed by K zero bytes, computed by a LOAD/SHIFT fill FSM for the latched
// reflected polynomial. Lookups are served with one cycle of latency.
//
// Read interface: a request is presented by rd_en/rd_addr and is always
// accepted (no backpressure). Exactly one cycle later rd_valid pulses; rd_hit
// tells whether ready was 1 when the request was sampled, and rd_data carries
// the table word on a hit and zero otherwise.
module crc_lut_gen
    import crc_lut_pkg::*;
#(
    parameter int unsigned          WIDTH       = 32,
    parameter int unsigned          ADDR_BITS   = 8,
    parameter int unsigned          ADV_BITS    = 6,
    parameter int unsigned          UNROLL      = 1,
    parameter logic [WIDTH-1:0]     DEF_POLY    = 32'hEDB88320,
    parameter logic [ADV_BITS-1:0]  DEF_ADVANCE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [WIDTH-1:0]     cfg_poly,
    input  logic [ADV_BITS-1:0]  cfg_advance,
    output logic                 busy,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_valid,
    output logic                 rd_hit,
    output logic [WIDTH-1:0]     rd_data,
    output logic [1:0]           dbg_state
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    // Holds 8*(K+1) for the largest K with headroom.
    localparam int unsigned CNT_W = ADV_BITS + 4;
    localparam int          SH    = $clog2(UNROLL);

    crc_state_e            state;
    logic                  start_pend;
    logic [ADDR_BITS-1:0]  idx;
    logic [CNT_W-1:0]      cnt;
    logic [WIDTH-1:0]      r;
    logic [WIDTH-1:0]      poly;
    logic [ADV_BITS-1:0]   adv;
    logic [WIDTH-1:0]      r_next;
    logic [CNT_W-1:0]      n_last;
    logic                  wr_en;

    logic [WIDTH-1:0] mem [DEPTH];

    // Last SHIFT cycle index for one entry: 8*(K+1)/UNROLL - 1.
    assign n_last = ((CNT_W'(adv) + CNT_W'(1)) << (3 - SH)) - CNT_W'(1);
    assign wr_en  = (state == ST_SHIFT) && (cnt == n_last);

    assign dbg_state = state;

    crc_lut_stepper #(
        .WIDTH  (WIDTH),
        .UNROLL (UNROLL)
    ) u_stepper (
        .r_in  (r),
        .poly  (poly),
        .r_out (r_next)
    );

    // Fill FSM. Reset parks in IDLE with a pending start so the default fill
    // begins in LOAD on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            start_pend <= 1'b1;
            busy       <= 1'b0;
            ready      <= 1'b0;
            poly       <= DEF_POLY;
            adv        <= DEF_ADVANCE;
            idx        <= '0;
            cnt        <= '0;
            r          <= '0;
        end else if (cfg_start || start_pend) begin
            // A restart abandons whatever was partially written.
            start_pend <= 1'b0;
            if (cfg_start) begin
                poly <= cfg_poly;
                adv  <= cfg_advance;
            end
            state <= ST_LOAD;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            ready <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    r     <= WIDTH'(idx);
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    r <= r_next;
                    if (cnt == n_last) begin
                        if (idx == ADDR_BITS'(DEPTH - 1)) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            idx   <= idx + ADDR_BITS'(1);
                            state <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Table write port: the finished entry lands on the last SHIFT cycle.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= r_next;
        end
    end

    // Registered lookup port; data is gated to zero unless the table was ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_hit   <= rd_en && ready;
            rd_data  <= (rd_en && ready) ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_crc_lut_gen.sv
// Directed bench for crc_lut_gen: an UNROLL=1 instance covers reset, default
// table contents, reprogramming, abort and reset mid-fill; an UNROLL=8
// instance covers the wide-step fill with a large advance.
module tb_crc_lut_gen;

    localparam logic [31:0] P_CRC32  = 32'hEDB88320;
    localparam logic [31:0] P_CRC32C = 32'h82F63B78;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- UNROLL=1 instance ----------------
    logic        cfg_start;
    logic [31:0] cfg_poly;
    logic [5:0]  cfg_advance;
    logic        busy, ready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_valid, rd_hit;
    logic [31:0] rd_data;
    logic [1:0]  dbg_state;

    crc_lut_gen #(.UNROLL(1)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_poly(cfg_poly), .cfg_advance(cfg_advance),
        .busy(busy), .ready(ready),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
        .dbg_state(dbg_state)
    );

    // ---------------- UNROLL=8 instance ----------------
    logic        cfg_start8;
    logic [31:0] cfg_poly8;
    logic [5:0]  cfg_advance8;
    logic        busy8, ready8;
    logic        rd_en8;
    logic [7:0]  rd_addr8;
    logic        rd_valid8, rd_hit8;
    logic [31:0] rd_data8;
    logic [1:0]  dbg_state8;

    crc_lut_gen #(.UNROLL(8)) dut8 (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start8), .cfg_poly(cfg_poly8), .cfg_advance(cfg_advance8),
        .busy(busy8), .ready(ready8),
        .rd_en(rd_en8), .rd_addr(rd_addr8),
        .rd_valid(rd_valid8), .rd_hit(rd_hit8), .rd_data(rd_data8),
        .dbg_state(dbg_state8)
    );

    // Reference: byte i followed by k zero bytes, one bit per step.
    function automatic logic [31:0] model(input int i, input logic [31:0] poly, input int k);
        logic [31:0] r;
        r = 32'(i);
        for (int s = 0; s < 8 * (k + 1); s++) begin
            r = r[0] ? ((r >> 1) ^ poly) : (r >> 1);
        end
        return r;
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic read_one(input logic [7:0] a, output logic v, output logic h, output logic [31:0] d);
        rd_en = 1'b1; rd_addr = a;
        @(posedge clk); @(negedge clk);
        v = rd_valid; h = rd_hit; d = rd_data;
        rd_en = 1'b0;
    endtask

    task automatic read_one8(input logic [7:0] a, output logic v, output logic h, output logic [31:0] d);
        rd_en8 = 1'b1; rd_addr8 = a;
        @(posedge clk); @(negedge clk);
        v = rd_valid8; h = rd_hit8; d = rd_data8;
        rd_en8 = 1'b0;
    endtask

    task automatic pulse_cfg(input logic [31:0] p, input logic [5:0] k);
        cfg_start = 1'b1; cfg_poly = p; cfg_advance = k;
        @(posedge clk); @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Clock edges until ready is seen; -1 if the budget runs out.
    task automatic wait_ready(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); @(negedge clk);
            if (ready) begin n = c; break; end
        end
    endtask

    task automatic wait_ready8(input int budget, output int n);
        n = -1;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clk); @(negedge clk);
            if (ready8) begin n = c; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int n;
        rst = 1'b1; rd_en = 1'b1; rd_addr = 8'h01;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (ready !== 1'b0)   begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_hit !== 1'b0)  begin errors++; $display("FAIL reset_rd_hit got %b exp 0", rd_hit); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
        rst = 1'b0; rd_en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1 || ready !== 1'b0 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL reset_release got busy=%b ready=%b state=%0d exp busy=1 ready=0 state=1", busy, ready, dbg_state);
        end
        wait_ready(8000, n);
        checks++; if (n != 2304) begin errors++; $display("FAIL default_fill_time got %0d exp 2304", n); end
    endtask

    task automatic test_defaults();
        logic [7:0]  addrs [5];
        logic [31:0] exps  [5];
        logic v, h; logic [31:0] d;
        addrs = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hFF};
        exps  = '{32'h00000000, 32'h77073096, 32'hEE0E612C, 32'hEDB88320, 32'h2D02EF8D};
        for (int i = 0; i < 5; i++) begin
            read_one(addrs[i], v, h, d);
            checks++;
            if (v !== 1'b1 || h !== 1'b1 || d !== exps[i]) begin
                errors++;
                $display("FAIL default_entry[%h] got v=%b h=%b d=%h exp v=1 h=1 d=%h", addrs[i], v, h, d, exps[i]);
            end
        end
    endtask

    task automatic test_read_before_ready();
        int n;
        logic v, h; logic [31:0] d;
        pulse_cfg(P_CRC32, 6'd0);
        read_one(8'h01, v, h, d);
        checks++; if (v !== 1'b1 || h !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL read_during_fill got v=%b h=%b d=%h exp v=1 h=0 d=0", v, h, d);
        end
        wait_ready(8000, n);
        checks++; if (n != 2303) begin errors++; $display("FAIL refill_time got %0d exp 2303", n); end
        read_one(8'h01, v, h, d);
        checks++; if (v !== 1'b1 || h !== 1'b1 || d !== 32'h77073096) begin
            errors++; $display("FAIL read_after_fill got v=%b h=%b d=%h exp v=1 h=1 d=77073096", v, h, d);
        end
    endtask

    task automatic test_reprogram();
        int n;
        logic v, h; logic [31:0] d;
        // Read in the same cycle as cfg_start still hits the old table.
        cfg_start = 1'b1; cfg_poly = P_CRC32C; cfg_advance = 6'd0;
        rd_en = 1'b1; rd_addr = 8'h01;
        @(posedge clk); @(negedge clk);
        cfg_start = 1'b0; rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== 32'h77073096) begin
            errors++; $display("FAIL read_with_cfg got v=%b h=%b d=%h exp v=1 h=1 d=77073096", rd_valid, rd_hit, rd_data);
        end
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL reprogram_drop got ready=%b busy=%b exp ready=0 busy=1", ready, busy);
        end
        wait_ready(8000, n);
        checks++; if (n != 2304) begin errors++; $display("FAIL crc32c_fill_time got %0d exp 2304", n); end
        read_one(8'h01, v, h, d);
        checks++; if (h !== 1'b1 || d !== 32'hF26B8303) begin
            errors++; $display("FAIL crc32c_entry[01] got h=%b d=%h exp h=1 d=f26b8303", h, d);
        end
        read_one(8'hFF, v, h, d);
        checks++; if (h !== 1'b1 || d !== 32'hAD7D5351) begin
            errors++; $display("FAIL crc32c_entry[ff] got h=%b d=%h exp h=1 d=ad7d5351", h, d);
        end
    endtask

    task automatic test_abort();
        int n;
        logic v, h; logic [31:0] d;
        pulse_cfg(P_CRC32, 6'd0);
        repeat (499) @(negedge clk);
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_fill_status got ready=%b busy=%b exp ready=0 busy=1", ready, busy);
        end
        pulse_cfg(P_CRC32, 6'd1);
        checks++; if (ready !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL abort_restart got ready=%b busy=%b state=%0d exp 0 1 1", ready, busy, dbg_state);
        end
        wait_ready(8000, n);
        checks++; if (n != 17 * 256) begin errors++; $display("FAIL k1_fill_time got %0d exp %0d", n, 17 * 256); end
        for (int i = 0; i < 256; i++) begin
            read_one(8'(i), v, h, d);
            checks++;
            if (h !== 1'b1 || d !== model(i, P_CRC32, 1)) begin
                errors++; $display("FAIL k1_entry[%0d] got h=%b d=%h exp h=1 d=%h", i, h, d, model(i, P_CRC32, 1));
            end
        end
    endtask

    task automatic test_unroll8();
        int n;
        logic v, h; logic [31:0] d;
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL u8_default_ready got %b exp 1", ready8); end
        cfg_start8 = 1'b1; cfg_poly8 = P_CRC32; cfg_advance8 = 6'd25;
        @(posedge clk); @(negedge clk);
        cfg_start8 = 1'b0;
        checks++; if (ready8 !== 1'b0 || busy8 !== 1'b1) begin
            errors++; $display("FAIL u8_restart got ready=%b busy=%b exp ready=0 busy=1", ready8, busy8);
        end
        wait_ready8(10000, n);
        checks++; if (n != 27 * 256) begin errors++; $display("FAIL u8_fill_time got %0d exp %0d", n, 27 * 256); end
        for (int i = 0; i < 256; i++) begin
            read_one8(8'(i), v, h, d);
            checks++;
            if (v !== 1'b1 || h !== 1'b1 || d !== model(i, P_CRC32, 25)) begin
                errors++; $display("FAIL u8_entry[%0d] got v=%b h=%b d=%h exp d=%h", i, v, h, d, model(i, P_CRC32, 25));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp_d;
        // Non-default fill, interrupted by reset: defaults must come back.
        pulse_cfg(P_CRC32C, 6'd3);
        repeat (300) @(negedge clk);
        rst = 1'b1; rd_en = 1'b1; rd_addr = 8'h05;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b0 || ready !== 1'b0 || rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL midfill_reset got busy=%b ready=%b v=%b h=%b d=%h exp all 0", busy, ready, rd_valid, rd_hit, rd_data);
        end
        rst = 1'b0; rd_en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin
            errors++; $display("FAIL midfill_restart got busy=%b state=%0d exp busy=1 state=1", busy, dbg_state);
        end
        wait_ready(8000, n);
        checks++; if (n != 2304) begin errors++; $display("FAIL post_reset_fill_time got %0d exp 2304", n); end
        // Streaming reads: response for address i-1 is observed while i is driven.
        for (int i = 0; i <= 256; i++) begin
            if (i > 0) begin
                exp_d = model(i - 1, P_CRC32, 0);
                checks++;
                if (rd_valid !== 1'b1 || rd_hit !== 1'b1 || rd_data !== exp_d) begin
                    errors++; $display("FAIL stream[%0d] got v=%b h=%b d=%h exp v=1 h=1 d=%h", i - 1, rd_valid, rd_hit, rd_data, exp_d);
                end
            end
            if (i < 256) begin
                rd_en = 1'b1; rd_addr = 8'(i);
            end else begin
                rd_en = 1'b0;
            end
            @(posedge clk); @(negedge clk);
        end
        checks++; if (rd_valid !== 1'b0 || rd_hit !== 1'b0 || rd_data !== 32'h0) begin
            errors++; $display("FAIL stream_end got v=%b h=%b d=%h exp 0 0 0", rd_valid, rd_hit, rd_data);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;  cfg_poly = '0;  cfg_advance = '0;  rd_en = 1'b0;  rd_addr = '0;
        cfg_start8 = 1'b0; cfg_poly8 = '0; cfg_advance8 = '0; rd_en8 = 1'b0; rd_addr8 = '0;
        @(negedge clk);
        test_reset();
        test_defaults();
        test_read_before_ready();
        test_reprogram();
        test_abort();
        test_unroll8();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
